// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port command arbiter: FSM states and the
// packed command word carried on the mem_cmd stream.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWrite,
        StRead,
        StDone
    } arb_state_t;

    typedef struct packed {
        logic        read;
        logic [31:0] addr;
        logic [31:0] len;
    } mem_cmd_t;

    localparam int unsigned CMD_WIDTH = $bits(mem_cmd_t);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant_onehot,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    always_comb begin
        logic [IDX_W-1:0] cand;
        grant_idx    = '0;
        any          = 1'b0;
        cand         = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                grant_idx = cand;
            end
        end
        grant_onehot = '0;
        if (any) begin
            grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
        end
    end

endmodule

// File: rtl/mem_cmd_arbiter.sv
// Shares the single memory port among NUM_REQ requesters, one transaction at
// a time, granting round-robin and routing write/read data for the grantee.
module mem_cmd_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MEM_WIDTH = 32,
    parameter int unsigned CMD_WIDTH = 65,
    parameter int unsigned MAX_LEN   = 256
) (
    input  logic                           clk,
    input  logic                           aresetn,
    input  logic [NUM_REQ-1:0]             req_cmd_valid,
    output logic [NUM_REQ-1:0]             req_cmd_ready,
    input  logic [NUM_REQ*CMD_WIDTH-1:0]   req_cmd_data,
    input  logic [NUM_REQ-1:0]             req_wr_valid,
    output logic [NUM_REQ-1:0]             req_wr_ready,
    input  logic [NUM_REQ*MEM_WIDTH-1:0]   req_wr_data,
    output logic [NUM_REQ-1:0]             req_rd_valid,
    input  logic [NUM_REQ-1:0]             req_rd_ready,
    output logic [MEM_WIDTH-1:0]           req_rd_data,
    output logic                           mem_cmd_valid,
    input  logic                           mem_cmd_ready,
    output logic [CMD_WIDTH-1:0]           mem_cmd_data,
    output logic                           mem_wr_valid,
    input  logic                           mem_wr_ready,
    output logic [MEM_WIDTH-1:0]           mem_wr_data,
    input  logic                           mem_rd_valid,
    output logic                           mem_rd_ready,
    input  logic [MEM_WIDTH-1:0]           mem_rd_data,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy
);

    import mem_arb_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [CNT_W-1:0] count_q, count_d;
    mem_cmd_t         cmd_q, cmd_d;

    logic [CMD_WIDTH-1:0] cmd_arr [NUM_REQ];
    logic [MEM_WIDTH-1:0] wr_arr  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign cmd_arr[i] = req_cmd_data[i*CMD_WIDTH +: CMD_WIDTH];
        assign wr_arr[i]  = req_wr_data[i*MEM_WIDTH +: MEM_WIDTH];
    end

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req         (req_cmd_valid),
        .ptr         (rr_q),
        .grant_onehot(pick_onehot),
        .grant_idx   (pick_idx),
        .any         (pick_any)
    );

    mem_cmd_t cmd_pick;

    always_comb begin
        cmd_pick = mem_cmd_t'(cmd_arr[pick_idx]);
        if (cmd_pick.len > 32'(MAX_LEN)) begin
            cmd_pick.len = 32'(MAX_LEN);
        end
    end

    assign mem_cmd_data = cmd_q;
    assign grant_id     = grant_q;
    assign busy         = (state_q != StIdle);

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        grant_d       = grant_q;
        count_d       = count_q;
        cmd_d         = cmd_q;
        req_cmd_ready = '0;
        req_wr_ready  = '0;
        req_rd_valid  = '0;
        req_rd_data   = '0;
        mem_cmd_valid = 1'b0;
        mem_wr_valid  = 1'b0;
        mem_wr_data   = '0;
        mem_rd_ready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Command is popped from the requester on the grant edge itself.
                if (pick_any && aresetn) begin
                    req_cmd_ready = pick_onehot;
                    cmd_d         = cmd_pick;
                    grant_d       = pick_idx;
                    state_d       = StCmd;
                end
            end
            StCmd: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) begin
                    count_d = cmd_q.len[CNT_W-1:0];
                    if (cmd_q.len == '0) begin
                        state_d = StDone;
                    end else if (cmd_q.read) begin
                        state_d = StRead;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                mem_wr_valid          = req_wr_valid[grant_q];
                mem_wr_data           = wr_arr[grant_q];
                req_wr_ready[grant_q] = mem_wr_ready;
                if (mem_wr_valid && mem_wr_ready) begin
                    count_d = count_q - 1'b1;
                    if (count_q == CNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StRead: begin
                req_rd_valid[grant_q] = mem_rd_valid;
                req_rd_data           = mem_rd_data;
                mem_rd_ready          = req_rd_ready[grant_q];
                if (mem_rd_valid && mem_rd_ready) begin
                    count_d = count_q - 1'b1;
                    if (count_q == CNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                rr_d    = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
            rr_q    <= '0;
            grant_q <= '0;
            count_q <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            count_q <= count_d;
            cmd_q   <= cmd_d;
        end
    end

endmodule

// File: tb/tb_mem_cmd_arbiter.sv
// Scoreboard bench for mem_cmd_arbiter: requester/memory models feed queues,
// expected transfers are queued at stimulus time and checked at handshakes.
`timescale 1ns/1ps
module tb_mem_cmd_arbiter;

    import mem_arb_pkg::*;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned MEM_WIDTH = 32;
    localparam int unsigned CW        = 65;
    localparam int unsigned MAX_LEN   = 256;

    logic                         clk = 1'b0;
    logic                         aresetn = 1'b0;
    logic [NUM_REQ-1:0]           req_cmd_valid = '0;
    logic [NUM_REQ-1:0]           req_cmd_ready;
    logic [NUM_REQ*CW-1:0]        req_cmd_data = '0;
    logic [NUM_REQ-1:0]           req_wr_valid = '0;
    logic [NUM_REQ-1:0]           req_wr_ready;
    logic [NUM_REQ*MEM_WIDTH-1:0] req_wr_data = '0;
    logic [NUM_REQ-1:0]           req_rd_valid;
    logic [NUM_REQ-1:0]           req_rd_ready = '1;
    logic [MEM_WIDTH-1:0]         req_rd_data;
    logic                         mem_cmd_valid;
    logic                         mem_cmd_ready = 1'b1;
    logic [CW-1:0]                mem_cmd_data;
    logic                         mem_wr_valid;
    logic                         mem_wr_ready = 1'b1;
    logic [MEM_WIDTH-1:0]         mem_wr_data;
    logic                         mem_rd_valid = 1'b0;
    logic                         mem_rd_ready;
    logic [MEM_WIDTH-1:0]         mem_rd_data = '0;
    logic [1:0]                   grant_id;
    logic                         busy;

    mem_cmd_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MEM_WIDTH(MEM_WIDTH),
        .CMD_WIDTH(CW),
        .MAX_LEN  (MAX_LEN)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .req_cmd_valid(req_cmd_valid),
        .req_cmd_ready(req_cmd_ready),
        .req_cmd_data (req_cmd_data),
        .req_wr_valid (req_wr_valid),
        .req_wr_ready (req_wr_ready),
        .req_wr_data  (req_wr_data),
        .req_rd_valid (req_rd_valid),
        .req_rd_ready (req_rd_ready),
        .req_rd_data  (req_rd_data),
        .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_data (mem_cmd_data),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_ready (mem_wr_ready),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_ready (mem_rd_ready),
        .mem_rd_data  (mem_rd_data),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard (expected) and source (stimulus) queues
    mem_cmd_t    exp_cmd_q[$];
    logic [31:0] exp_wr_q[$];
    logic [33:0] exp_rd_q[$];
    int          exp_grant_q[$];

    mem_cmd_t    cmd_src[NUM_REQ][$];
    logic [31:0] wr_src[$];
    logic [31:0] rd_src[$];
    int          wr_id = 1;
    bit          bp_en = 1'b0;
    bit          spur_wr0 = 1'b0;

    logic [NUM_REQ-1:0] cmd_fired = '0;
    bit                 wr_fired = 1'b0;
    bit                 rd_fired = 1'b0;

    function automatic mem_cmd_t mk_cmd(input logic rd, input logic [31:0] addr,
                                        input logic [31:0] len);
        mem_cmd_t c;
        c.read = rd;
        c.addr = addr;
        c.len  = len;
        return c;
    endfunction

    task automatic issue(input int id, input mem_cmd_t c);
        mem_cmd_t e;
        e = c;
        if (e.len > MAX_LEN) e.len = MAX_LEN;
        cmd_src[id].push_back(c);
        exp_grant_q.push_back(id);
        exp_cmd_q.push_back(e);
    endtask

    // Requester and memory-side drivers; advance sources after observed handshakes.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cmd_fired[i] && cmd_src[i].size() > 0) void'(cmd_src[i].pop_front());
        end
        if (wr_fired && wr_src.size() > 0) void'(wr_src.pop_front());
        if (rd_fired && rd_src.size() > 0) void'(rd_src.pop_front());
        cmd_fired = '0;
        wr_fired  = 1'b0;
        rd_fired  = 1'b0;

        req_cmd_valid = '0;
        req_cmd_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cmd_src[i].size() > 0) begin
                req_cmd_valid[i]          = 1'b1;
                req_cmd_data[i*CW +: CW]  = cmd_src[i][0];
            end
        end
        req_wr_valid = '0;
        req_wr_data  = '0;
        if (wr_src.size() > 0) begin
            if (!(bp_en && $urandom_range(0, 3) == 0)) begin
                req_wr_valid[wr_id]          = 1'b1;
                req_wr_data[wr_id*32 +: 32]  = wr_src[0];
            end
        end else if (spur_wr0) begin
            req_wr_valid[0]    = 1'b1;
            req_wr_data[31:0]  = 32'hBAD0_BAD0;
        end
        mem_cmd_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_wr_ready  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_rd_valid  = (rd_src.size() > 0) && !(bp_en && $urandom_range(0, 3) == 0);
        mem_rd_data   = mem_rd_valid ? rd_src[0] : '0;
    end

    // Monitor: inputs are stable at negedge, so valid&ready here fires at the next posedge.
    always @(negedge clk) begin
        if (aresetn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_cmd_valid[i] && req_cmd_ready[i]) begin
                    cmd_fired[i] = 1'b1;
                    if (exp_grant_q.size() > 0) check_eq("grant", i, exp_grant_q.pop_front());
                    else check_eq("grant_extra", i, NUM_REQ);
                end
                if (req_rd_valid[i] && req_rd_ready[i]) begin
                    if (exp_rd_q.size() > 0)
                        check_eq("rd_data", {i[1:0], req_rd_data}, exp_rd_q.pop_front());
                    else check_eq("rd_extra", {i[1:0], req_rd_data}, '1);
                end
            end
            if (mem_cmd_valid && mem_cmd_ready) begin
                if (exp_cmd_q.size() > 0) check_eq("mem_cmd", mem_cmd_data, exp_cmd_q.pop_front());
                else check_eq("cmd_extra", mem_cmd_data, '1);
            end
            if (mem_wr_valid && mem_wr_ready) begin
                if (exp_wr_q.size() > 0) check_eq("wr_data", mem_wr_data, exp_wr_q.pop_front());
                else check_eq("wr_extra", mem_wr_data, '1);
            end
            wr_fired = req_wr_valid[wr_id] && req_wr_ready[wr_id];
            rd_fired = mem_rd_valid && mem_rd_ready;
        end
    end

    task automatic wait_drain(input int budget);
        int n;
        bit timed_out;
        n = 0;
        @(negedge clk);
        while (n < budget && (exp_cmd_q.size() > 0 || exp_wr_q.size() > 0 ||
               exp_rd_q.size() > 0 || exp_grant_q.size() > 0 || busy)) begin
            @(negedge clk);
            n++;
        end
        timed_out = (n >= budget);
        check_eq("drain_timeout", timed_out, 0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_busy"}, busy, 0);
        check_eq({pfx, "_grant_id"}, grant_id, 0);
        check_eq({pfx, "_mem_cmd_valid"}, mem_cmd_valid, 0);
        check_eq({pfx, "_mem_cmd_data"}, mem_cmd_data, 0);
        check_eq({pfx, "_mem_wr_valid"}, mem_wr_valid, 0);
        check_eq({pfx, "_mem_wr_data"}, mem_wr_data, 0);
        check_eq({pfx, "_mem_rd_ready"}, mem_rd_ready, 0);
        check_eq({pfx, "_req_cmd_ready"}, req_cmd_ready, 0);
        check_eq({pfx, "_req_wr_ready"}, req_wr_ready, 0);
        check_eq({pfx, "_req_rd_valid"}, req_rd_valid, 0);
        check_eq({pfx, "_req_rd_data"}, req_rd_data, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] w;

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        check_reset_outputs("rst");
        step();
        aresetn = 1'b1;
        step();

        // Single write from requester 1
        wr_id = 1;
        for (int i = 0; i < 4; i++) begin
            w = 32'hA000_0000 + 32'(i);
            wr_src.push_back(w);
            exp_wr_q.push_back(w);
        end
        issue(1, mk_cmd(1'b0, 32'h100, 32'd4));
        wait_drain(100);
        check_eq("wr1_grant_id", grant_id, 1);
        check_eq("wr1_busy", busy, 0);

        // Isolation: spurious write valid on 0, read data offered before READ
        step();
        spur_wr0 = 1'b1;
        for (int i = 0; i < 3; i++) rd_src.push_back(32'hC000_0000 + 32'(i));
        repeat (3) begin
            @(negedge clk);
            check_eq("iso_pre_rd_ready", mem_rd_ready, 0);
            check_eq("iso_pre_wr0_ready", req_wr_ready[0], 0);
        end
        step();
        for (int i = 0; i < 3; i++) exp_rd_q.push_back({2'd2, 32'hC000_0000 + 32'(i)});
        issue(2, mk_cmd(1'b1, 32'h300, 32'd3));
        n = 0;
        while ((exp_rd_q.size() > 0 || busy) && n < 200) begin
            @(negedge clk);
            check_eq("iso_wr0_ready", req_wr_ready[0], 0);
            n++;
        end
        check_eq("iso_timeout", n >= 200, 0);
        check_eq("iso_grant_id", grant_id, 2);
        step();
        spur_wr0 = 1'b0;

        // Backpressure: random stalls on write, requester read-ready held low mid-read
        bp_en = 1'b1;
        wr_id = 3;
        for (int i = 0; i < 8; i++) begin
            w = 32'hB000_0000 + 32'(i);
            wr_src.push_back(w);
            exp_wr_q.push_back(w);
        end
        issue(3, mk_cmd(1'b0, 32'h400, 32'd8));
        wait_drain(500);
        check_eq("bp_wr_grant_id", grant_id, 3);
        step();
        for (int i = 0; i < 8; i++) begin
            w = 32'hD000_0000 + 32'(i);
            rd_src.push_back(w);
            exp_rd_q.push_back({2'd0, w});
        end
        issue(0, mk_cmd(1'b1, 32'h500, 32'd8));
        n = 0;
        while (exp_rd_q.size() > 5 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_rd_progress_timeout", n >= 300, 0);
        step();
        req_rd_ready = '0;
        repeat (10) begin
            @(negedge clk);
            check_eq("bp_rd_hold_ready", mem_rd_ready, 0);
        end
        step();
        req_rd_ready = '1;
        wait_drain(500);
        check_eq("bp_rd_grant_id", grant_id, 0);
        bp_en = 1'b0;
        step();

        // Length 0: command only, offered read data must stay untouched
        rd_src.push_back(32'hEEEE_0000);
        issue(1, mk_cmd(1'b1, 32'h600, 32'd0));
        wait_drain(100);
        check_eq("len0_rd_untouched", rd_src.size(), 1);
        check_eq("len0_busy", busy, 0);
        step();
        rd_src.delete();

        // Clamp: len 1000 becomes 256 words on the port
        wr_id = 1;
        for (int i = 0; i < 300; i++) begin
            w = 32'h7000_0000 + 32'(i);
            wr_src.push_back(w);
            if (i < 256) exp_wr_q.push_back(w);
        end
        issue(1, mk_cmd(1'b0, 32'h700, 32'd1000));
        wait_drain(2000);
        check_eq("clamp_words_left", wr_src.size(), 44);
        step();
        wr_src.delete();
        step();

        // Reset mid-WRITE after 2 of 8 words (round-robin pointer is 2 here)
        wr_id = 1;
        for (int i = 0; i < 2; i++) begin
            w = 32'h8000_0000 + 32'(i);
            wr_src.push_back(w);
            exp_wr_q.push_back(w);
        end
        issue(1, mk_cmd(1'b0, 32'h800, 32'd8));
        n = 0;
        while ((exp_wr_q.size() > 0 || exp_cmd_q.size() > 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_wr_timeout", n >= 100, 0);
        repeat (2) step();
        check_eq("mid_wr_still_busy", busy, 1);
        aresetn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        issue(2, mk_cmd(1'b1, 32'h900, 32'd1));
        issue(0, mk_cmd(1'b1, 32'hA00, 32'd1));
        // Grant order after reset must start from pointer 0
        void'(exp_grant_q.pop_front());
        void'(exp_grant_q.pop_front());
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(2);
        begin
            mem_cmd_t c2, c0;
            c2 = exp_cmd_q.pop_front();
            c0 = exp_cmd_q.pop_front();
            exp_cmd_q.push_back(c0);
            exp_cmd_q.push_back(c2);
        end
        rd_src.push_back(32'h1111_0000);
        rd_src.push_back(32'h2222_0000);
        exp_rd_q.push_back({2'd0, 32'h1111_0000});
        exp_rd_q.push_back({2'd2, 32'h2222_0000});
        repeat (3) step();
        @(negedge clk);
        check_eq("midrst_cmd_ready_held", req_cmd_ready, 0);
        step();
        aresetn = 1'b1;
        wait_drain(200);
        check_eq("after_rst_grant_id", grant_id, 2);
        step();

        // Round robin: all four requesters, requester 0 twice
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            int id;
            id = i % 4;
            issue(id, mk_cmd(1'b1, 32'h1000 + 32'(i * 16), 32'd2));
            for (int k = 0; k < 2; k++) begin
                w = 32'h5000_0000 + 32'(i * 2 + k);
                rd_src.push_back(w);
                exp_rd_q.push_back({2'(id), w});
            end
        end
        wait_drain(500);
        check_eq("rr_last_grant_id", grant_id, 0);
        check_eq("rr_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
